sha256_msg_schedule: RTL and testbench

SHA-256 message-schedule generator that sits directly upstream of the round datapath: it accepts one 512-bit padded message block and streams the 64 schedule words W_0..W_63, one per clock, into the T1 computation feeding the working-variable registers (a..h). It also produces the one-cycle round-0 marker that drives the registers' `control` input to load the intermediate hash. A 16-word sliding window keeps storage at 512 bits.

---
 rtl/sha256_msg_schedule.sv | 92 +++++++++
 tb/tb_sha256_msg_schedule.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: loads one padded 512-bit block and streams
// W_0..W_63 one word per clock from a 16-word sliding window, stallable by hold.
module sha256_msg_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         hold,
    output logic [31:0]  w_out,
    output logic [5:0]   t_out,
    output logic         w_valid,
    output logic         first,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] win [16];
    logic [5:0]  t;
    logic        advance;
    logic        load;
    logic [31:0] new_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // win[k] holds W_{t+k}, so the recurrence taps for W_{t+16} sit at fixed slots.
    assign new_word = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        load      = 1'b0;
        w_valid   = 1'b0;
        first     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                w_valid = ~hold;
                first   = ~hold & (t == 6'd0);
                if (!hold) begin
                    advance = 1'b1;
                    if (t == 6'd63) state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            t     <= 6'd0;
            for (int i = 0; i < 16; i++) win[i] <= 32'd0;
        end else begin
            state <= state_nxt;
            if (load) begin
                t <= 6'd0;
                for (int i = 0; i < 16; i++) win[i] <= block_in[511 - 32*i -: 32];
            end else if (advance) begin
                // t wraps 63 -> 0 on the final advance into DONE.
                t <= t + 6'd1;
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= new_word;
            end
        end
    end

    assign w_out = win[0];
    assign t_out = t;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: directed and random blocks checked against a
// plain-arithmetic SHA-256 schedule model.
module tb_sha256_msg_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [511:0] block_in;
  logic         hold;
  logic [31:0]  w_out;
  logic [5:0]   t_out;
  logic         w_valid;
  logic         first;
  logic         busy;
  logic         done;

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_q[$];

  // per-block observations filled by collect_block
  logic [31:0] obs_w [64];
  logic [5:0]  obs_t [64];
  int          first_cnt;
  int          first_n;
  int          done_c;
  int          done_cnt;
  bit          timeout;
  bit          stall_vw;
  logic [5:0]  stall_t;

  localparam logic [511:0] ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};

  sha256_msg_schedule dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .block_in (block_in),
    .hold     (hold),
    .w_out    (w_out),
    .t_out    (t_out),
    .w_valid  (w_valid),
    .first    (first),
    .busy     (busy),
    .done     (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void model(input logic [511:0] blk);
    logic [31:0] w [64];
    exp_q = {};
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      logic [31:0] s0, s1;
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // driver: starts a block on the current negedge and records what the DUT streams
  task automatic collect_block(input logic [511:0] blk, input int hold_t, input int hold_n,
                               input int ign_t, input bit hold_done);
    int n = 0;
    int c = 0;
    int hc = 0;
    bit ign_done = 0;
    first_cnt = 0; first_n = -1; done_c = -1; done_cnt = 0;
    timeout = 0; stall_vw = 0; stall_t = '0;
    start = 1'b1; block_in = blk; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    forever begin
      hold  = 1'b0;
      start = 1'b0;
      if (n == hold_t && hc < hold_n) begin
        hold = 1'b1;
        hc++;
      end
      if (hold_done && n == 64) hold = 1'b1;
      if (n == ign_t && !ign_done) begin
        start = 1'b1;
        block_in = ~blk;
        ign_done = 1;
      end
      #1;
      if (hold && n < 64) begin
        stall_vw = stall_vw | w_valid;
        stall_t = t_out;
      end
      if (w_valid && n < 64) begin
        obs_w[n] = w_out;
        obs_t[n] = t_out;
        if (first) begin
          first_cnt++;
          first_n = n;
        end
        n++;
      end else if (first) begin
        first_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_c = c;
      end
      @(negedge clk);
      if (done_c >= 0) break;
      c++;
      if (c > 400) begin
        timeout = 1;
        break;
      end
    end
    hold = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hold = 1'b0; block_in = '0;
    #12;
    checks++; if (w_out !== 32'd0) begin fails++; $display("FAIL reset_w_out actual=%h required=0", w_out); end
    checks++; if (t_out !== 6'd0) begin fails++; $display("FAIL reset_t_out actual=%0d required=0", t_out); end
    checks++; if (w_valid !== 1'b0) begin fails++; $display("FAIL reset_w_valid actual=%b required=0", w_valid); end
    checks++; if (first !== 1'b0) begin fails++; $display("FAIL reset_first actual=%b required=0", first); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done actual=%b required=0", done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abc();
    model(ABC_BLK);
    collect_block(ABC_BLK, -1, 0, -1, 0);
    checks++; if (timeout) begin fails++; $display("FAIL abc_timeout actual=1 required=0"); end
    checks++; if (obs_w[0] !== 32'h61626380) begin fails++; $display("FAIL abc_w0 actual=%h required=61626380", obs_w[0]); end
    checks++; if (obs_w[15] !== 32'h00000018) begin fails++; $display("FAIL abc_w15 actual=%h required=00000018", obs_w[15]); end
    checks++; if (obs_w[16] !== 32'h61626380) begin fails++; $display("FAIL abc_w16 actual=%h required=61626380", obs_w[16]); end
    checks++; if (obs_w[17] !== 32'h000F0000) begin fails++; $display("FAIL abc_w17 actual=%h required=000F0000", obs_w[17]); end
    checks++; if (obs_w[63] !== 32'h12B1EDEB) begin fails++; $display("FAIL abc_w63 actual=%h required=12B1EDEB", obs_w[63]); end
    for (int i = 0; i < 64; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (obs_w[i] !== e) begin fails++; $display("FAIL abc_word t=%0d actual=%h required=%h", i, obs_w[i], e); end
      checks++; if (obs_t[i] !== 6'(i)) begin fails++; $display("FAIL abc_t_out idx=%0d actual=%0d required=%0d", i, obs_t[i], i); end
    end
    checks++; if (first_cnt !== 1 || first_n !== 0) begin fails++; $display("FAIL abc_first count=%0d at=%0d required count=1 at=0", first_cnt, first_n); end
    checks++; if (done_c !== 65) begin fails++; $display("FAIL abc_done_cycle actual=%0d required=65", done_c); end
    #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abc_idle_after_done done=%b busy=%b required 0 0", done, busy); end
  endtask

  task automatic test_stall();
    model(ABC_BLK);
    collect_block(ABC_BLK, 16, 3, -1, 0);
    checks++; if (stall_vw !== 1'b0) begin fails++; $display("FAIL stall_w_valid actual=1 required=0"); end
    checks++; if (stall_t !== 6'd16) begin fails++; $display("FAIL stall_t_out actual=%0d required=16", stall_t); end
    checks++; if (obs_w[16] !== 32'h61626380) begin fails++; $display("FAIL stall_w16 actual=%h required=61626380", obs_w[16]); end
    checks++; if (done_c !== 68) begin fails++; $display("FAIL stall_done_cycle actual=%0d required=68", done_c); end
    for (int i = 0; i < 64; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (obs_w[i] !== e) begin fails++; $display("FAIL stall_word t=%0d actual=%h required=%h", i, obs_w[i], e); end
    end
  endtask

  task automatic test_ignored_start();
    model(ABC_BLK);
    collect_block(ABC_BLK, -1, 0, 30, 0);
    checks++; if (obs_w[63] !== 32'h12B1EDEB) begin fails++; $display("FAIL ign_w63 actual=%h required=12B1EDEB", obs_w[63]); end
    checks++; if (done_c !== 65) begin fails++; $display("FAIL ign_done_cycle actual=%0d required=65", done_c); end
    for (int i = 0; i < 64; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (obs_w[i] !== e) begin fails++; $display("FAIL ign_word t=%0d actual=%h required=%h", i, obs_w[i], e); end
    end
  endtask

  task automatic test_back_to_back();
    for (int b = 0; b < 3; b++) begin
      logic [511:0] blk;
      blk = rand_block();
      model(blk);
      collect_block(blk, -1, 0, -1, 0);
      checks++; if (first_n !== 0 || obs_t[0] !== 6'd0) begin fails++; $display("FAIL b2b_first blk=%0d first_at=%0d t0=%0d required 0 0", b, first_n, obs_t[0]); end
      checks++; if (done_c !== 65) begin fails++; $display("FAIL b2b_done_cycle blk=%0d actual=%0d required=65", b, done_c); end
      for (int i = 0; i < 64; i++) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (obs_w[i] !== e) begin fails++; $display("FAIL b2b_word blk=%0d t=%0d actual=%h required=%h", b, i, obs_w[i], e); end
      end
    end
  endtask

  task automatic test_random_hold();
    for (int b = 0; b < 4; b++) begin
      logic [511:0] blk;
      int ht, hn;
      blk = rand_block();
      ht = $urandom_range(0, 63);
      hn = $urandom_range(1, 5);
      model(blk);
      collect_block(blk, ht, hn, -1, 1);
      checks++; if (done_c !== 65 + hn) begin fails++; $display("FAIL rhold_done_cycle blk=%0d actual=%0d required=%0d", b, done_c, 65 + hn); end
      checks++; if (first_cnt !== 1 || first_n !== 0) begin fails++; $display("FAIL rhold_first blk=%0d count=%0d at=%0d required count=1 at=0", b, first_cnt, first_n); end
      checks++; if (stall_vw !== 1'b0 || stall_t !== 6'(ht)) begin fails++; $display("FAIL rhold_stall blk=%0d valid=%b t=%0d required valid=0 t=%0d", b, stall_vw, stall_t, ht); end
      for (int i = 0; i < 64; i++) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++; if (obs_w[i] !== e) begin fails++; $display("FAIL rhold_word blk=%0d t=%0d actual=%h required=%h", b, i, obs_w[i], e); end
      end
    end
  endtask

  task automatic test_all_ones();
    logic [511:0] blk;
    blk = '1;
    model(blk);
    collect_block(blk, -1, 0, -1, 0);
    for (int i = 0; i < 64; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      checks++; if (obs_w[i] !== e) begin fails++; $display("FAIL ones_word t=%0d actual=%h required=%h", i, obs_w[i], e); end
    end
  endtask

  task automatic test_mid_reset();
    logic [511:0] blk;
    int cnt = 0;
    int guard = 0;
    blk = rand_block();
    start = 1'b1; block_in = blk; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    while (!(w_valid && t_out == 6'd20) && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    checks++; if (guard >= 200) begin fails++; $display("FAIL mreset_reach_t20 actual=timeout required=t20"); end
    rst = 1'b1;
    #1;
    checks++; if (w_out !== 32'd0 || t_out !== 6'd0) begin fails++; $display("FAIL mreset_data w=%h t=%0d required 0 0", w_out, t_out); end
    checks++; if (w_valid !== 1'b0 || first !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mreset_ctrl valid=%b first=%b busy=%b done=%b required 0000", w_valid, first, busy, done); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mreset_idle busy=%b required=0", busy); end
    @(negedge clk);
    blk = rand_block();
    model(blk);
    collect_block(blk, -1, 0, -1, 0);
    checks++; if (first_n !== 0) begin fails++; $display("FAIL mreset_new_first at=%0d required=0", first_n); end
    for (int i = 0; i < 64; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      if (i == 0 || i == 63) begin
        checks++; if (obs_w[i] !== e) begin fails++; $display("FAIL mreset_word t=%0d actual=%h required=%h", i, obs_w[i], e); end
      end
      cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_ignored_start();
    test_back_to_back();
    test_random_hold();
    test_all_ones();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
